// File: rtl/alu_chk_pkg.sv
// Shared types and the reference ALU model for the response checker.
// The opcode table lives here so every consumer computes the same expected result.
package alu_chk_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_NOTA  = 4'd5,
    OP_NAND  = 4'd6,
    OP_NOR   = 4'd7,
    OP_XNOR  = 4'd8,
    OP_SHL   = 4'd9,
    OP_SHR   = 4'd10,
    OP_ROL   = 4'd11,
    OP_ROR   = 4'd12,
    OP_INC   = 4'd13,
    OP_DEC   = 4'd14,
    OP_PASSB = 4'd15
  } alu_op_e;

  typedef struct packed {
    logic       co;
    logic [7:0] y;
  } alu_res_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } chk_state_e;

  typedef struct packed {
    alu_op_e  op;
    alu_res_t exp;
  } chk_entry_t;

  localparam int ENTRY_W = $bits(chk_entry_t);

  // Bit 8 of the 9-bit unsigned result doubles as carry/borrow for the arithmetic ops.
  function automatic alu_res_t alu_ref_f(input logic [7:0] a, input logic [7:0] b,
                                         input alu_op_e op);
    logic [8:0] r;
    r = '0;
    case (op)
      OP_ADD:   r = {1'b0, a} + {1'b0, b};
      OP_SUB:   r = {1'b0, a} - {1'b0, b};
      OP_AND:   r = {1'b0, a & b};
      OP_OR:    r = {1'b0, a | b};
      OP_XOR:   r = {1'b0, a ^ b};
      OP_NOTA:  r = {1'b0, ~a};
      OP_NAND:  r = {1'b0, ~(a & b)};
      OP_NOR:   r = {1'b0, ~(a | b)};
      OP_XNOR:  r = {1'b0, ~(a ^ b)};
      OP_SHL:   r = {a, 1'b0};
      OP_SHR:   r = {a[0], 1'b0, a[7:1]};
      OP_ROL:   r = {a[7], a[6:0], a[7]};
      OP_ROR:   r = {a[0], a[0], a[7:1]};
      OP_INC:   r = {1'b0, a} + 9'd1;
      OP_DEC:   r = {1'b0, a} - 9'd1;
      OP_PASSB: r = {1'b0, b};
      default:  r = '0;
    endcase
    return alu_res_t'(r);
  endfunction

endpackage

// File: rtl/alu_response_checker_if.sv
// Bundle of the transaction inputs and result/status outputs of the response checker.
// master = side that drives the ALU traffic, slave = the checker itself.
interface alu_response_checker_if #(
  parameter int CNT_W = 16
);
  logic             check_en;
  logic             clear;
  logic [7:0]       alu_a_in;
  logic [7:0]       alu_b_in;
  logic [3:0]       alu_opcode_in;
  logic [7:0]       alu_y_out;
  logic             alu_co_out;
  logic [CNT_W-1:0] pass_count;
  logic [CNT_W-1:0] fail_count;
  logic             error;
  logic             ff_valid;
  logic [3:0]       ff_opcode;
  logic [8:0]       ff_exp;
  logic [8:0]       ff_act;
  logic             busy;

  modport master (
    output check_en, clear, alu_a_in, alu_b_in, alu_opcode_in, alu_y_out, alu_co_out,
    input  pass_count, fail_count, error, ff_valid, ff_opcode, ff_exp, ff_act, busy
  );

  modport slave (
    input  check_en, clear, alu_a_in, alu_b_in, alu_opcode_in, alu_y_out, alu_co_out,
    output pass_count, fail_count, error, ff_valid, ff_opcode, ff_exp, ff_act, busy
  );
endinterface

// File: rtl/alu_chk_delay.sv
// DEPTH-stage valid/payload shift register with synchronous flush of all valids.
// DEPTH=0 degenerates to a wire so the compare happens in the issuing cycle.
module alu_chk_delay
  import alu_chk_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int WIDTH = ENTRY_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             pending_o,
  output logic             occupied_o
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ok;
    assign unused_ok  = ^{clk, rst_n, flush_i};
    assign valid_o    = valid_i;
    assign data_o     = data_i;
    assign pending_o  = 1'b0;
    assign occupied_o = 1'b0;
  end else begin : g_shift
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];

    // NOTE: every bit of valid_d/data_d is assigned on every pass, so no latch is inferred.
    always_comb begin
      valid_d[0] = valid_i & ~flush_i;
      data_d[0]  = data_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_d[i] = valid_q[i-1] & ~flush_i;
        data_d[i]  = data_q[i-1];
      end
    end

    // NOTE: non-blocking assignments let every stage sample its neighbour's old value.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= '0;
        // NOTE: the payload array is reset too, so no state bit is left undefined after reset.
        for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
      end
    end

    // pending: entries that will still be in flight after the next edge
    always_comb begin
      pending_o = 1'b0;
      for (int i = 0; i < DEPTH - 1; i++) pending_o = pending_o | valid_q[i];
    end

    assign valid_o    = valid_q[DEPTH-1];
    assign data_o     = data_q[DEPTH-1];
    assign occupied_o = |valid_q;
  end

endmodule

// File: rtl/alu_response_checker.sv
// Response-side ALU checker: delays the reference result by LATENCY cycles, compares it
// with the DUT result, and keeps saturating counters, a sticky error and a first-fail capture.
module alu_response_checker
  import alu_chk_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  alu_response_checker_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  alu_op_e    op_in;
  chk_entry_t new_entry, due_entry;
  alu_res_t   act_res;
  logic       due_valid, pending, occupied;
  logic       cmp_en, cmp_match;

  chk_state_e       state_q, state_d;
  logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d;
  logic             error_q, error_d, ffv_q, ffv_d, busy;
  alu_op_e          ff_op_q, ff_op_d;
  alu_res_t         ff_exp_q, ff_exp_d, ff_act_q, ff_act_d;

  assign op_in     = alu_op_e'(bus.alu_opcode_in);
  assign new_entry = '{op: op_in, exp: alu_ref_f(bus.alu_a_in, bus.alu_b_in, op_in)};
  assign act_res   = alu_res_t'({bus.alu_co_out, bus.alu_y_out});

  alu_chk_delay #(
    .DEPTH (LATENCY),
    .WIDTH (ENTRY_W)
  ) u_delay (
    .clk        (clk),
    .rst_n      (reset),
    .flush_i    (bus.clear),
    .valid_i    (bus.check_en),
    .data_i     (new_entry),
    .valid_o    (due_valid),
    .data_o     (due_entry),
    .pending_o  (pending),
    .occupied_o (occupied)
  );

  // clear in the same cycle as a compare discards that compare
  assign cmp_en    = due_valid & ~bus.clear;
  assign cmp_match = (due_entry.exp == act_res);

  always_comb begin
    pass_d   = pass_q;
    fail_d   = fail_q;
    error_d  = error_q;
    ffv_d    = ffv_q;
    ff_op_d  = ff_op_q;
    ff_exp_d = ff_exp_q;
    ff_act_d = ff_act_q;
    if (bus.clear) begin
      pass_d   = '0;
      fail_d   = '0;
      error_d  = 1'b0;
      ffv_d    = 1'b0;
      ff_op_d  = OP_ADD;
      ff_exp_d = '0;
      ff_act_d = '0;
    end else if (cmp_en) begin
      if (cmp_match) begin
        if (pass_q != CNT_MAX) pass_d = pass_q + 1'b1;
      end else begin
        if (fail_q != CNT_MAX) fail_d = fail_q + 1'b1;
        error_d = 1'b1;
        if (!ffv_q) begin
          ffv_d    = 1'b1;
          ff_op_d  = due_entry.op;
          ff_exp_d = due_entry.exp;
          ff_act_d = act_res;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.check_en) state_d = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (!bus.check_en && !pending) state_d = ST_IDLE;
      end
      ST_ERR:  busy = occupied;
      default: state_d = ST_IDLE;
    endcase
    if (cmp_en && !cmp_match) state_d = ST_ERR;
    if (bus.clear) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      pass_q   <= '0;
      fail_q   <= '0;
      error_q  <= 1'b0;
      ffv_q    <= 1'b0;
      ff_op_q  <= OP_ADD;
      ff_exp_q <= '0;
      ff_act_q <= '0;
    end else begin
      state_q  <= state_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      error_q  <= error_d;
      ffv_q    <= ffv_d;
      ff_op_q  <= ff_op_d;
      ff_exp_q <= ff_exp_d;
      ff_act_q <= ff_act_d;
    end
  end

  assign bus.pass_count = pass_q;
  assign bus.fail_count = fail_q;
  assign bus.error      = error_q;
  assign bus.ff_valid   = ffv_q;
  assign bus.ff_opcode  = ff_op_q;
  assign bus.ff_exp     = ff_exp_q;
  assign bus.ff_act     = ff_act_q;
  assign bus.busy       = busy;

endmodule

// File: tb/tb_alu_response_checker.sv
// Self-checking bench: plays the ALU DUT (optionally corrupting results) and tracks
// the expected checker state with a transaction-level model.
module tb_alu_response_checker;
  import alu_chk_pkg::*;

  localparam int LAT = 1;
  localparam int CW  = 16;
  localparam logic [CW-1:0] CMAX = '1;

  typedef struct {
    bit         v;
    logic [3:0] op;
    logic [8:0] exp;
    logic [8:0] act;
  } txn_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  alu_response_checker_if #(.CNT_W(CW)) bus ();

  alu_response_checker #(.LATENCY(LAT), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  txn_t          pipe [LAT];
  logic [CW-1:0] m_pass, m_fail;
  bit            m_err, m_ffv;
  logic [3:0]    m_ffop;
  logic [8:0]    m_ffexp, m_ffact;

  // Reference results straight from the opcode table, using plain integer arithmetic.
  function automatic logic [8:0] model_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] op);
    int unsigned ua, ub, y;
    bit co;
    ua = a; ub = b; y = 0; co = 1'b0;
    case (op)
      4'd0:  begin y = ua + ub;           co = (y > 255);     end
      4'd1:  begin y = ua + 256 - ub;     co = (ua < ub);     end
      4'd2:  y = ua & ub;
      4'd3:  y = ua | ub;
      4'd4:  y = ua ^ ub;
      4'd5:  y = ~ua;
      4'd6:  y = ~(ua & ub);
      4'd7:  y = ~(ua | ub);
      4'd8:  y = ~(ua ^ ub);
      4'd9:  begin y = ua * 2;            co = (ua >= 128);   end
      4'd10: begin y = ua / 2;            co = (ua % 2 == 1); end
      4'd11: begin y = ua * 2 + ua / 128; co = (ua >= 128);   end
      4'd12: begin y = ua / 2 + (ua % 2) * 128; co = (ua % 2 == 1); end
      4'd13: begin y = ua + 1;            co = (ua == 255);   end
      4'd14: begin y = ua + 255;          co = (ua == 0);     end
      default: y = ub;
    endcase
    return {co, 8'(y % 256)};
  endfunction

  task automatic model_reset();
    m_pass = '0; m_fail = '0; m_err = 1'b0; m_ffv = 1'b0;
    m_ffop = '0; m_ffexp = '0; m_ffact = '0;
    for (int i = 0; i < LAT; i++) pipe[i] = '{v: 1'b0, op: 4'd0, exp: 9'd0, act: 9'd0};
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    bit in_flight;
    in_flight = 1'b0;
    for (int i = 0; i < LAT; i++) in_flight |= pipe[i].v;
    check({tag, ".pass_count"}, 32'(bus.pass_count), 32'(m_pass));
    check({tag, ".fail_count"}, 32'(bus.fail_count), 32'(m_fail));
    check({tag, ".error"},      32'(bus.error),      32'(m_err));
    check({tag, ".ff_valid"},   32'(bus.ff_valid),   32'(m_ffv));
    check({tag, ".ff_opcode"},  32'(bus.ff_opcode),  32'(m_ffop));
    check({tag, ".ff_exp"},     32'(bus.ff_exp),     32'(m_ffexp));
    check({tag, ".ff_act"},     32'(bus.ff_act),     32'(m_ffact));
    check({tag, ".busy"},       32'(bus.busy),       32'(in_flight));
  endtask

  // One clock cycle: present a transaction plus the DUT response that is due now,
  // advance the model across the coming edge, and return at the following negedge.
  task automatic drive(input bit en, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] op, input bit corrupt, input bit clr);
    txn_t       due;
    logic [8:0] r_exp;
    due   = pipe[LAT-1];
    r_exp = model_ref(a, b, op);
    bus.check_en      = en;
    bus.clear         = clr;
    bus.alu_a_in      = a;
    bus.alu_b_in      = b;
    bus.alu_opcode_in = op;
    if (due.v) begin
      bus.alu_co_out = due.act[8];
      bus.alu_y_out  = due.act[7:0];
    end else begin
      bus.alu_co_out = 1'($urandom);
      bus.alu_y_out  = 8'($urandom);
    end
    if (clr) begin
      model_reset();
    end else begin
      if (due.v) begin
        if (due.act === due.exp) begin
          if (m_pass != CMAX) m_pass++;
        end else begin
          if (m_fail != CMAX) m_fail++;
          m_err = 1'b1;
          if (!m_ffv) begin
            m_ffv = 1'b1; m_ffop = due.op; m_ffexp = due.exp; m_ffact = due.act;
          end
        end
      end
      for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = '{v: en, op: op, exp: r_exp, act: corrupt ? (r_exp ^ 9'h100) : r_exp};
    end
    @(negedge clk);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL timeout: run did not finish within the time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bus.check_en = 1'b0; bus.clear = 1'b0;
    bus.alu_a_in = '0; bus.alu_b_in = '0; bus.alu_opcode_in = '0;
    bus.alu_y_out = '0; bus.alu_co_out = 1'b0;
    model_reset();

    // reset state
    @(negedge clk);
    check("reset.pass_count", 32'(bus.pass_count), 32'd0);
    check_model("reset");
    reset = 1'b1;

    // ADD FF+01 answered correctly
    drive(1'b1, 8'hFF, 8'h01, 4'd0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0);
    check("add.pass_count", 32'(bus.pass_count), 32'd1);
    check("add.fail_count", 32'(bus.fail_count), 32'd0);
    check("add.error",      32'(bus.error),      32'd0);
    check_model("add");

    // SUB 10-20 answered with the wrong borrow
    drive(1'b1, 8'h10, 8'h20, 4'd1, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0);
    check("sub.fail_count", 32'(bus.fail_count), 32'd1);
    check("sub.error",      32'(bus.error),      32'd1);
    check("sub.ff_opcode",  32'(bus.ff_opcode),  32'h1);
    check("sub.ff_exp",     32'(bus.ff_exp),     32'h1F0);
    check("sub.ff_act",     32'(bus.ff_act),     32'h0F0);
    check("sub.fsm_err",    32'(dut.state_q),    32'(ST_ERR));
    check_model("sub");

    // second mismatch: SHL 81 answered y=02 co=0, capture must keep the SUB
    drive(1'b1, 8'h81, 8'h00, 4'd9, 1'b1, 1'b0);
    check("err_inflight.busy", 32'(bus.busy), 32'd1);
    drive(1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0);
    check("shl.fail_count", 32'(bus.fail_count), 32'd2);
    check("shl.ff_exp",     32'(bus.ff_exp),     32'h1F0);
    check("shl.busy",       32'(bus.busy),       32'd0);
    check_model("shl");

    // all 16 opcodes back to back after a clear
    drive(1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1);
    check_model("clear1");
    for (int op = 0; op < 16; op++) drive(1'b1, 8'hA5, 8'h3C, 4'(op), 1'b0, 1'b0);
    check("ops.busy_before_fall", 32'(bus.busy), 32'd1);
    drive(1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0);
    check("ops.pass_count", 32'(bus.pass_count), 32'd16);
    check("ops.busy_after_fall", 32'(bus.busy), 32'd0);
    check_model("ops");

    // random traffic with bubbles, occasional corruption and clears
    for (int n = 0; n < 300; n++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 4'($urandom),
            $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0);
      check_model("rand");
    end

    // clear in the same cycle as a mismatching compare and a new check_en
    drive(1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1);
    drive(1'b1, 8'hFF, 8'h01, 4'd0, 1'b0, 1'b0);
    drive(1'b1, 8'h10, 8'h20, 4'd1, 1'b1, 1'b0);
    check("pre_clear.pass_count", 32'(bus.pass_count), 32'd1);
    drive(1'b1, 8'h55, 8'hAA, 4'd3, 1'b0, 1'b1);
    check("clr_cmp.fail_count", 32'(bus.fail_count), 32'd0);
    check("clr_cmp.error",      32'(bus.error),      32'd0);
    check("clr_cmp.ff_valid",   32'(bus.ff_valid),   32'd0);
    check("clr_cmp.busy",       32'(bus.busy),       32'd0);
    drive(1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0);
    check("clr_cmp.pass_count", 32'(bus.pass_count), 32'd0);
    check_model("clr_cmp");

    // pass counter saturation
    drive(1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1);
    for (int n = 0; n < 65535; n++)
      drive(1'b1, 8'($urandom), 8'($urandom), 4'($urandom), 1'b0, 1'b0);
    drive(1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0);
    check("sat.pass_full", 32'(bus.pass_count), 32'hFFFF);
    drive(1'b1, 8'h12, 8'h34, 4'd0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0);
    check("sat.pass_hold", 32'(bus.pass_count), 32'hFFFF);
    check_model("sat");

    // asynchronous reset mid-stream with a mismatch recorded and an entry in flight
    drive(1'b1, 8'h10, 8'h20, 4'd1, 1'b1, 1'b0);
    drive(1'b1, 8'h01, 8'h02, 4'd0, 1'b0, 1'b0);
    check("pre_rst.error", 32'(bus.error), 32'd1);
    #2 reset = 1'b0;
    model_reset();
    #1;
    check("rst.pass_count", 32'(bus.pass_count), 32'd0);
    check("rst.ff_valid",   32'(bus.ff_valid),   32'd0);
    check_model("rst_async");
    @(negedge clk);
    check_model("rst_hold");
    reset = 1'b1;

    // warm-up: the first cycle after release has nothing to compare
    drive(1'b1, 8'h33, 8'h44, 4'd4, 1'b0, 1'b0);
    check("warm.pass_count", 32'(bus.pass_count), 32'd0);
    check("warm.fail_count", 32'(bus.fail_count), 32'd0);
    check_model("warm");
    drive(1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0);
    check("warm.first_pass", 32'(bus.pass_count), 32'd1);
    check_model("post_warm");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
